// File: rtl/fifo_16_drain_if.sv
// Bundle between fifo_16, the drain controller and the downstream cell consumer.
// Also carries the controller's FSM state and skid fill level for observation.
interface fifo_16_drain_if #(
    parameter int AWIDTH = 9,
    parameter int OCC_W  = 10
);
    logic              fifo_flush;
    logic              fifo_wr_en;
    logic              fifo_rd_en;
    logic [AWIDTH-1:0] fifo_dout;
    logic [AWIDTH-2:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_valid;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;
    logic              frame_err;
    logic [1:0]        dbg_state;
    logic [1:0]        dbg_buf_cnt;

    // Stream handshake: a word transfers on every cycle where out_valid && out_ready;
    // while out_valid && !out_ready the out_* fields hold their value.
    modport slave (
        input  fifo_flush, fifo_wr_en, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_sop, out_eop, out_valid,
               occupancy, frame_err, dbg_state, dbg_buf_cnt
    );

    modport master (
        output fifo_flush, fifo_wr_en, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_sop, out_eop, out_valid,
               occupancy, frame_err, dbg_state, dbg_buf_cnt
    );
endinterface

// File: rtl/fifo_16_drain.sv
// Read-side controller for fifo_16: tracks occupancy, issues rd_en, catches the
// 1-cycle-late words in a 2-entry skid buffer and frames them into sop/eop cells.
module fifo_16_drain #(
    parameter int AWIDTH   = 9,
    parameter int DEPTH    = 512,
    parameter int CELL_LEN = 53,
    parameter int OCC_W    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_16_drain_if.slave  bus
);
    localparam int BW  = AWIDTH - 1;
    localparam int EW  = AWIDTH + 1;
    localparam int WCW = $clog2(CELL_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_CELL = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             inflight_q;
    logic             frame_err_q, err_d;
    logic [EW-1:0]    skid_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop, push, rd_en, wr_ok, marker;
    logic [EW-1:0]    push_word, head;
    logic [2:0]       pending;
    logic [BW-1:0]    in_byte;

    assign pop     = (cnt_q != 2'd0) && bus.out_ready;
    assign pending = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en   = !bus.fifo_flush && (occ_q != '0) && (pending < 3'd2);
    // A write into a full FIFO only lands when a read frees a slot in the same cycle.
    assign wr_ok   = bus.fifo_wr_en && ((occ_q < OCC_W'(DEPTH)) || rd_en);
    assign marker  = bus.fifo_dout[AWIDTH-1];
    assign in_byte = bus.fifo_dout[BW-1:0];

    always_comb begin
        occ_d = occ_q;
        if (wr_ok && !rd_en)      occ_d = occ_q + OCC_W'(1);
        else if (!wr_ok && rd_en) occ_d = occ_q - OCC_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        push      = 1'b0;
        push_word = '0;
        err_d     = 1'b0;
        if (inflight_q) begin
            case (state_q)
                IDLE: begin
                    if (marker) begin
                        push      = 1'b1;
                        push_word = {1'b1, 1'b0, in_byte};
                        wcnt_d    = WCW'(1);
                        state_d   = IN_CELL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                IN_CELL: begin
                    push = 1'b1;
                    if (marker) begin
                        // Early SOP: old cell is abandoned without eop, new cell starts here.
                        err_d     = 1'b1;
                        push_word = {1'b1, 1'b0, in_byte};
                        wcnt_d    = WCW'(1);
                    end else if (wcnt_q == WCW'(CELL_LEN - 1)) begin
                        push_word = {1'b0, 1'b1, in_byte};
                        wcnt_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        push_word = {1'b0, 1'b0, in_byte};
                        wcnt_d    = wcnt_q + WCW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            frame_err_q <= 1'b0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else if (bus.fifo_flush) begin
            // Clearing inflight_q discards the word that returns right after the flush.
            state_q     <= IDLE;
            wcnt_q      <= '0;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            occ_q       <= occ_d;
            inflight_q  <= rd_en;
            frame_err_q <= err_d;
            cnt_q       <= cnt_d;
            if (push) begin
                skid_q[wr_ptr_q] <= push_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign head            = skid_q[rd_ptr_q];
    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_data    = bus.out_valid ? head[BW-1:0] : '0;
    assign bus.out_sop     = bus.out_valid & head[EW-1];
    assign bus.out_eop     = bus.out_valid & head[EW-2];
    assign bus.fifo_rd_en  = rd_en;
    assign bus.occupancy   = occ_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_buf_cnt = cnt_q;
endmodule

// File: tb/tb_fifo_16_drain.sv
// Bench for fifo_16_drain: a queue-based fifo_16 stand-in feeds the DUT, and a
// cell-level reference predicts every output word and the number of framing errors.
module tb_fifo_16_drain;
  localparam int DEPTH    = 512;
  localparam int CELL_LEN = 53;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_16_drain_if #(.AWIDTH(9), .OCC_W(10)) bus ();

  fifo_16_drain #(.AWIDTH(9), .DEPTH(DEPTH), .CELL_LEN(CELL_LEN), .OCC_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [8:0] fifo_q[$];
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_err  = 0;
  int obs_err  = 0;
  bit in_cell  = 1'b0;
  int cell_pos = 0;
  bit hold_prev = 1'b0;
  logic [9:0] prev_word = '0;
  bit last_valid = 1'b0;
  int rdy_mode = 0;
  bit tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cell-level reference: a cell is a marker word plus CELL_LEN-1 plain words.
  function automatic void model_write(input logic [8:0] w);
    if (w[8]) begin
      if (in_cell) exp_err++;
      exp_q.push_back({2'b10, w[7:0]});
      in_cell  = 1'b1;
      cell_pos = 1;
    end else if (!in_cell) begin
      exp_err++;
    end else begin
      cell_pos++;
      if (cell_pos == CELL_LEN) begin
        exp_q.push_back({2'b01, w[7:0]});
        in_cell  = 1'b0;
        cell_pos = 0;
      end else begin
        exp_q.push_back({2'b00, w[7:0]});
      end
    end
  endfunction

  function automatic bit rdy_pick();
    case (rdy_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin tog = ~tog; return tog; end
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step(input bit wr, input logic [8:0] wd, input bit rdy, input bit fl);
    logic [9:0] obs_word;
    logic [8:0] nxt;
    bit have_nxt;
    have_nxt = 1'b0;
    nxt = '0;
    @(negedge clk);
    bus.fifo_wr_en = wr;
    bus.out_ready  = rdy;
    bus.fifo_flush = fl;
    #1;
    obs_word   = {bus.out_sop, bus.out_eop, bus.out_data};
    last_valid = bus.out_valid;
    if (bus.frame_err) obs_err++;
    check("occupancy", 32'(bus.occupancy), 32'(fifo_q.size()));
    if (fifo_q.size() == 0) check("rd_en_at_empty", 32'(bus.fifo_rd_en), 32'd0);
    if (fl) check("rd_en_in_flush", 32'(bus.fifo_rd_en), 32'd0);
    check("buf_cnt_le2", 32'(bus.dbg_buf_cnt <= 2'd2), 32'd1);
    if (hold_prev) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_word", 32'(obs_word), 32'(prev_word));
    end
    if (bus.out_valid && rdy) begin
      if (exp_q.size() == 0) check("out_when_none_expected", 32'(bus.out_valid), 32'd0);
      else check("out_word", 32'(obs_word), 32'(exp_q.pop_front()));
    end
    hold_prev = bus.out_valid && !rdy && !fl;
    prev_word = obs_word;
    if (fl) begin
      fifo_q.delete();
      exp_q.delete();
      in_cell  = 1'b0;
      cell_pos = 0;
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() != 0) begin
        nxt = fifo_q.pop_front();
        have_nxt = 1'b1;
      end
      if (wr && fifo_q.size() < DEPTH) begin
        fifo_q.push_back(wd);
        model_write(wd);
      end
    end
    @(posedge clk);
    #1;
    if (have_nxt) bus.fifo_dout = nxt;
  endtask

  task automatic write_words(input int n, input int first_pos);
    for (int i = 0; i < n; i++)
      step(1'b1, {1'(first_pos + i == 0), 8'($urandom_range(0, 255))}, rdy_pick(), 1'b0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    step(1'b0, '0, 1'b1, 1'b0);
    while (i < 3000 && !(exp_q.size() == 0 && fifo_q.size() == 0 && !last_valid)) begin
      step(1'b0, '0, 1'b1, 1'b0);
      i++;
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_occupancy", 32'(bus.occupancy), 32'd0);
    check("drain_pending_words", 32'(exp_q.size()), 32'd0);
    check("frame_err_count", 32'(obs_err), 32'(exp_err));
  endtask

  initial begin
    int vcount;
    int len;
    bus.fifo_wr_en = 1'b0;
    bus.out_ready  = 1'b0;
    bus.fifo_flush = 1'b0;
    bus.fifo_dout  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_out_fields", 32'({bus.out_sop, bus.out_eop, bus.out_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three writes, consumer stalled, then drain and finish the cell.
    rdy_mode = 0;
    write_words(3, 0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("three_writes_occ", 32'(bus.occupancy), 32'd1);
    check("three_writes_buf", 32'(bus.dbg_buf_cnt), 32'd2);
    drain();
    write_words(CELL_LEN - 3, 3);
    drain();
    check("cell_done_state", 32'(bus.dbg_state), 32'd0);

    // Two back-to-back cells released in one burst.
    write_words(CELL_LEN, 0);
    write_words(CELL_LEN, 0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    vcount = 0;
    for (int i = 0; i < 2 * CELL_LEN; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      vcount += int'(last_valid);
    end
    check("b2b_valid_cycles", 32'(vcount), 32'(2 * CELL_LEN));
    drain();

    // Toggled backpressure mid-cell.
    rdy_mode = 2;
    write_words(CELL_LEN, 0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, rdy_pick(), 1'b0);
    drain();

    // Early SOP at word 20, then a complete cell.
    rdy_mode = 3;
    write_words(20, 0);
    write_words(CELL_LEN, 0);
    drain();

    // Stray plain word while idle.
    step(1'b1, {1'b0, 8'h5a}, 1'b1, 1'b0);
    write_words(CELL_LEN, 0);
    drain();

    // Fill to capacity, overfill, simultaneous write+read, then flush mid-cell.
    rdy_mode = 0;
    for (int c = 0; c < 9; c++) write_words(CELL_LEN, 0);
    write_words(DEPTH + 2 - 9 * CELL_LEN, 0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("full_occupancy", 32'(bus.occupancy), 32'(DEPTH));
    step(1'b1, {1'b0, 8'h11}, 1'b0, 1'b0);
    check("full_drop_occ", 32'(bus.occupancy), 32'(DEPTH));
    step(1'b1, {1'b0, 8'h22}, 1'b1, 1'b0);
    check("full_wr_rd_occ", 32'(bus.occupancy), 32'(DEPTH));
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("flush_occupancy", 32'(bus.occupancy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_state", 32'(bus.dbg_state), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_discard_valid", 32'(bus.out_valid), 32'd0);
    drain();

    // Randomized cells with truncations and stray words.
    rdy_mode = 3;
    for (int c = 0; c < 8; c++) begin
      if ($urandom_range(0, 3) == 0) step(1'b1, {1'b0, 8'($urandom_range(0, 255))}, rdy_pick(), 1'b0);
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, CELL_LEN - 1)) : CELL_LEN;
      write_words(len, 0);
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) step(1'b0, '0, rdy_pick(), 1'b0);
    end
    write_words(CELL_LEN, 0);
    drain();

    // Asynchronous reset between clock edges with data in flight.
    rdy_mode = 0;
    write_words(5, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_occ", 32'(bus.occupancy), 32'd0);
    check("async_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
